// File: rtl/fifo_unit_pkg.sv
// Shared definitions for the fifo_unit slice: default geometry and the
// encoding of the effective push/pop operation seen by the control block.
package fifo_unit_pkg;

    localparam int FIFO_DEFAULT_ADDR_WIDTH = 3;
    localparam int FIFO_DEFAULT_DATA_WIDTH = 8;

    // Effective operation for one clock edge, encoded as {push, pop}
    // after full/empty gating has been applied.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage : fifo_unit_pkg

// File: rtl/fifo_ctrl.sv
// Pointer and flag control for the FIFO. Gates requests against the
// registered flags, advances the pointers and keeps full/empty exact.
module fifo_ctrl
    import fifo_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] w_ptr, w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr, r_ptr_nxt;
    logic                  full_nxt, empty_nxt;
    logic                  we, re;
    fifo_op_e              op;

    // A write into a full FIFO and a read from an empty one are dropped here,
    // so overflow/underflow can never move a pointer.
    assign we = wr & ~full;
    assign re = rd & ~empty;
    assign op = fifo_op_e'({we, re});

    // Next pointers and flags from the effective operation.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_ptr_nxt = w_ptr;
        r_ptr_nxt = r_ptr;
        full_nxt  = full;
        empty_nxt = empty;
        unique case (op)
            OP_IDLE: ;
            OP_POP: begin
                r_ptr_nxt = r_ptr + PTR_ONE;
                full_nxt  = 1'b0;
                empty_nxt = ((r_ptr + PTR_ONE) == w_ptr);
            end
            OP_PUSH: begin
                w_ptr_nxt = w_ptr + PTR_ONE;
                empty_nxt = 1'b0;
                full_nxt  = ((w_ptr + PTR_ONE) == r_ptr);
            end
            OP_BOTH: begin
                // Occupancy is unchanged, so the flags hold.
                w_ptr_nxt = w_ptr + PTR_ONE;
                r_ptr_nxt = r_ptr + PTR_ONE;
            end
            default: ;
        endcase
    end

    // State register; reset empties the FIFO immediately.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            w_ptr <= w_ptr_nxt;
            r_ptr <= r_ptr_nxt;
            full  <= full_nxt;
            empty <= empty_nxt;
        end
    end

    assign w_addr = w_ptr;
    assign r_addr = r_ptr;

endmodule : fifo_ctrl

// File: rtl/fifo_reg_file.sv
// Storage array for the FIFO: one synchronous write port and one
// asynchronous read port, so the head word is visible with no latency.
module fifo_reg_file #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an effective push.
    // NOTE: the array has no reset; its content is only meaningful once the
    // pointers say an entry is valid, and a reset here would only cost flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule : fifo_reg_file

// File: rtl/fifo_unit.sv
// Single-clock first-word-fall-through FIFO: control block plus register
// file. r_data always shows the oldest entry; rd pops it.
module fifo_unit
    import fifo_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty
);

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  we;

    // Storage is written only when there is room for the word.
    assign we = wr & ~full;

    fifo_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr),
        .rd      (rd),
        .w_addr  (w_addr),
        .r_addr  (r_addr),
        .full    (full),
        .empty   (empty)
    );

    fifo_reg_file #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_reg_file (
        .clk    (clk),
        .we     (we),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_addr (r_addr),
        .r_data (r_data)
    );

endmodule : fifo_unit

// File: tb/tb_fifo_unit.sv
// Bench for fifo_unit: directed scenarios followed by random traffic, all
// compared against a queue-based occupancy model of the FIFO.
module tb_fifo_unit;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr;
    logic          rd;
    logic [DW-1:0] w_data;
    logic [DW-1:0] r_data;
    logic          full;
    logic          empty;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] model_q[$];

    always #5 clk = ~clk;

    fifo_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr),
        .rd      (rd),
        .w_data  (w_data),
        .r_data  (r_data),
        .full    (full),
        .empty   (empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare the DUT against the model: flags always, head word when valid.
    task automatic compare(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
        if (model_q.size() != 0) begin
            check({tag, "_head"}, 32'(r_data), 32'(model_q[0]));
        end
    endtask

    // One clock of traffic: drive at the falling edge, let the rising edge
    // act, update the model, and return at the next falling edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        bit do_push;
        bit do_pop;
        wr     = w;
        rd     = r;
        w_data = d;
        @(posedge clk);
        do_push = w && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() != 0);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] t2_wr [6] = '{8'd0, 8'd9, 8'd3, 8'd6, 8'd1, 8'd3};
        logic [DW-1:0] t2_rd [8] = '{8'd8, 8'd2, 8'd0, 8'd9, 8'd3, 8'd6, 8'd1, 8'd3};
        logic [DW-1:0] t5_wr [6] = '{8'd20, 8'd30, 8'd55, 8'd16, 8'd175, 8'd111};
        logic [DW-1:0] t5_rd [8] = '{8'd10, 8'd9, 8'd20, 8'd30, 8'd55, 8'd16, 8'd175, 8'd111};

        reset_n = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        w_data  = '0;
        repeat (2) @(negedge clk);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full",  32'(full),  32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Test 1: basic fall-through and single pop.
        step(1'b1, 1'b0, 8'd5);
        check("t1_first_head", 32'(r_data), 32'd5);
        check("t1_first_empty", 32'(empty), 32'd0);
        step(1'b1, 1'b0, 8'd8);
        step(1'b1, 1'b0, 8'd2);
        check("t1_head", 32'(r_data), 32'd5);
        compare("t1_after_writes");
        step(1'b0, 1'b1, '0);
        check("t1_pop", 32'(r_data), 32'd8);

        // Test 2: fill to full, overflow write dropped, drain in order.
        foreach (t2_wr[i]) begin
            step(1'b1, 1'b0, t2_wr[i]);
            compare("t2_fill");
        end
        check("t2_full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 8'hAA);
        check("t2_overflow_full", 32'(full), 32'd1);
        compare("t2_overflow");
        foreach (t2_rd[i]) begin
            check("t2_drain", 32'(r_data), 32'(t2_rd[i]));
            step(1'b0, 1'b1, '0);
        end
        check("t2_empty", 32'(empty), 32'd1);
        check("t2_not_full", 32'(full), 32'd0);

        // Test 3: simultaneous wr&rd on empty, then with one entry.
        step(1'b1, 1'b1, 8'd7);
        check("t3_empty", 32'(empty), 32'd0);
        check("t3_head7", 32'(r_data), 32'd7);
        step(1'b1, 1'b1, 8'd5);
        check("t3_head5", 32'(r_data), 32'd5);
        compare("t3_both");
        step(1'b0, 1'b1, '0);
        check("t3_drained", 32'(empty), 32'd1);

        // Test 4: underflow read is ignored.
        step(1'b0, 1'b1, '0);
        check("t4_empty", 32'(empty), 32'd1);
        check("t4_full", 32'(full), 32'd0);
        compare("t4_underflow");

        // Test 5: push/pop pairs, then fill and drain across the pointer wrap.
        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd120);
        step(1'b1, 1'b1, 8'd10);
        check("t5_head120", 32'(r_data), 32'd120);
        step(1'b1, 1'b1, 8'd9);
        check("t5_head10", 32'(r_data), 32'd10);
        foreach (t5_wr[i]) begin
            step(1'b1, 1'b0, t5_wr[i]);
            compare("t5_fill");
        end
        check("t5_full", 32'(full), 32'd1);
        step(1'b1, 1'b1, 8'd77);
        check("t5_full_both_deasserts", 32'(full), 32'd0);
        check("t5_full_both_head", 32'(r_data), 32'(t5_rd[1]));
        step(1'b1, 1'b0, 8'd200);
        model_q.delete();
        // Reload the known sequence: drain what is left and refill in order.
        while (!empty && errors == 0 && checks < 100000) step(1'b0, 1'b1, '0);
        model_q.delete();
        compare("t5_refill_start");
        foreach (t5_rd[i]) step(1'b1, 1'b0, t5_rd[i]);
        check("t5_refull", 32'(full), 32'd1);
        foreach (t5_rd[i]) begin
            check("t5_drain", 32'(r_data), 32'(t5_rd[i]));
            step(1'b0, 1'b1, '0);
        end
        check("t5_empty", 32'(empty), 32'd1);

        // Random traffic in phases biased toward filling and toward draining.
        for (int p = 0; p < 6; p++) begin
            for (int n = 0; n < 60; n++) begin
                logic w_r, r_r;
                w_r = ($urandom_range(99) < ((p % 2 == 0) ? 75 : 25));
                r_r = ($urandom_range(99) < ((p % 2 == 0) ? 25 : 75));
                step(w_r, r_r, DW'($urandom));
                compare("rand");
            end
        end

        // Test 6: asynchronous reset in the middle of a write burst.
        while (model_q.size() < DEPTH) step(1'b1, 1'b0, DW'($urandom));
        check("t6_full_before", 32'(full), 32'd1);
        wr     = 1'b1;
        w_data = 8'h5A;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_empty", 32'(empty), 32'd1);
        check("t6_async_full",  32'(full),  32'd0);
        model_q.delete();
        wr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        compare("t6_released");
        step(1'b1, 1'b0, 8'd44);
        check("t6_after_reset_head", 32'(r_data), 32'd44);
        compare("t6_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_unit
